// File: rtl/lib_pkt_arbiter_mux.sv
// ============================================================================
// Module   : lib_pkt_arbiter_mux
// Brief    : Packet-aware round-robin arbiter and mux. Grants one requester
//            per packet, then holds that grant until the EOP beat is accepted.
//            The output stage is a single registered beat that can load a new
//            beat while the current one drains.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lib_pkt_arbiter_mux #(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int LNUM_INPUTS = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    input  logic [NUM_INPUTS-1:0]            in_eop,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_eop,
    output logic [LNUM_INPUTS-1:0]           out_src,
    input  logic                             out_ready
);

    // After reset the pointer sits on the last input so input 0 is searched first.
    localparam logic [LNUM_INPUTS-1:0] C_LAST_IDX = LNUM_INPUTS'(NUM_INPUTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [LNUM_INPUTS-1:0]  r_last_grant;
    logic [LNUM_INPUTS-1:0]  w_last_grant_next;
    logic [LNUM_INPUTS-1:0]  r_lock_id;
    logic [LNUM_INPUTS-1:0]  w_lock_id_next;

    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_eop;
    logic [LNUM_INPUTS-1:0]  r_out_src;

    logic                    w_load_en;
    logic [LNUM_INPUTS-1:0]  w_winner;
    logic                    w_winner_found;
    logic [LNUM_INPUTS-1:0]  w_sel;
    logic [NUM_INPUTS-1:0]   w_ready;
    logic                    w_xfer;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_sel_eop;

    // The output register can take a beat when it is empty or draining this cycle.
    assign w_load_en = !r_out_valid || out_ready;

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        int w_idx;
        w_idx          = 0;
        w_winner       = '0;
        w_winner_found = 1'b0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            w_idx = (int'(r_last_grant) + k) % NUM_INPUTS;
            if (!w_winner_found && in_valid[LNUM_INPUTS'(w_idx)]) begin
                w_winner       = LNUM_INPUTS'(w_idx);
                w_winner_found = 1'b1;
            end
        end
    end

    // Grant generation: depends only on state, in_valid and load_en (never on data/eop).
    always_comb begin
        w_ready = '0;
        w_sel   = w_winner;
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    w_sel = w_winner;
                    if (w_winner_found) begin
                        w_ready[w_winner] = w_load_en;
                    end
                end
                ST_LOCKED: begin
                    // Only the locked requester may proceed; a gap on it is a bubble.
                    w_sel              = r_lock_id;
                    w_ready[r_lock_id] = w_load_en;
                end
                default: begin
                    w_sel = w_winner;
                end
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign w_xfer    = |(in_valid & w_ready);
    assign w_sel_eop = in_eop[w_sel];

    // Payload mux for the selected requester.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (LNUM_INPUTS'(i) == w_sel) begin
                w_sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic: lock on a non-EOP beat, release and advance pointer on EOP.
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_lock_id_next    = r_lock_id;
        if (w_xfer) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_eop) begin
                        w_last_grant_next = w_sel;
                    end else begin
                        w_state_next   = ST_LOCKED;
                        w_lock_id_next = w_sel;
                    end
                end
                ST_LOCKED: begin
                    if (w_sel_eop) begin
                        w_state_next      = ST_IDLE;
                        w_last_grant_next = r_lock_id;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= C_LAST_IDX;
            r_lock_id    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_lock_id    <= w_lock_id_next;
        end
    end

    // Output beat register: load on input transfer, clear on drain, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_eop   <= 1'b0;
            r_out_src   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_eop   <= w_sel_eop;
            r_out_src   <= w_sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_eop   = r_out_eop;
    assign out_src   = r_out_src;

endmodule

`default_nettype wire
